decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Instruction-decode stage that sits directly upstream of the register-file/pipelined-ALU pair.
- Latches a 32-bit instruction word into an instruction register (IR).
- Decodes the IR into one-hot Aselect/Bselect register selects and the ALU function S/Cin.
- Delays the one-hot write select Dselect so it lines up with the ALU result on dbus.
- Detects read-after-write hazards against in-flight destinations, stalls fetch and issues bubbles.

Parameters:
DLAT, 2, cycles between an instruction's Aselect/Bselect/S/Cin and its Dselect; equals alupipe result latency; legal range 1..4.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous, active-low
ibus  in  32  instruction word from fetch
ivalid  in  1  ibus holds a valid instruction this cycle
stall  out  1  combinational; fetch must hold ibus/ivalid while high
Aselect  out  32  one-hot register select, operand A
Bselect  out  32  one-hot register select, operand B
Dselect  out  32  one-hot write select; all-zero means no write
S  out  3  ALU function
Cin  out  1  ALU carry-in

Behaviour:
- Instruction format: op=[31:26], rs=[25:21] (A), rt=[20:16] (B), rd=[15:11] (D). Bits [10:0] are ignored.
- Opcode map (op -> S, Cin):
  - XOR 000000 -> 000, 0
  - AND 000001 -> 110, 0
  - SUB 000010 -> 011, 1
  - ADD 000011 -> 010, 0
  - OR 000100 -> 100, 0
  - NOR 000101 -> 101, 0
  - Any other op is a NOP.
- IR load: at the rising edge, if stall=0, IR <= ibus and irv <= ivalid. If stall=1, IR and irv hold.
- Issue, combinational from IR during the cycle after capture:
  - If irv=1, the op is legal and stall=0: Aselect=1<<rs, Bselect=1<<rt, S and Cin per the opcode map.
  - Otherwise a bubble: Aselect=Bselect=32'h1, S=000, Cin=0, and the destination pushed is "none".
- Destination pipeline: DLAT stages, each 32-bit one-hot.
  - Each edge, stage1 <= issued destination, and stage k+1 <= stage k.
  - Dselect = stage DLAT.
  - Issued destination = 1<<rd, except rd=0 or a bubble pushes 32'h0, so R0 is never written.
- Hazard detection:
  - stall=1 when irv=1, the op is legal, and rs or rt is nonzero and matches the rd held in any stage 1..DLAT.
  - The stage currently driving Dselect counts as in flight, because its write completes only at the end of the cycle.
  - rs=0 or rt=0 never stalls.
- Stall timing:
  - A back-to-back dependent pair stalls exactly DLAT cycles.
  - One independent instruction between producer and consumer gives DLAT-1 stall cycles.
  - Zero stall cycles once the gap is DLAT or more.
- Reset (async assert, mid-operation included):
  - irv=0, all destination stages = 0.
  - Outputs: Aselect=Bselect=32'h1, Dselect=0, S=000, Cin=0, stall=0.
  - Instructions in flight are discarded and never written.
  - Deassertion is treated as synchronous to clk by the system.
- Simultaneous stall and ivalid: the input is ignored, not lost, because fetch holds it.

Decomposition:
- decode_pkg holds:
  - opcode constants and their S/Cin encodings
  - instruction field bit positions
  - the NOP/bubble select constant 32'h1
  - the DLAT bounds
- Sub-module onehot5to32: combinational 5-bit to 32-bit one-hot decoder.
  - Instantiated three times: rs, rt, rd.
  - Its output is compared bitwise-AND against the pipeline stages for the hazard check.

Test Plan:
- Reset: rst_n=0 mid-stream -> immediately Aselect=Bselect=32'h1, Dselect=0, S=0, Cin=0, stall=0, all without waiting for a clock.
- Single ADD r3=r1+r2 (op 000011, rs=1, rt=2, rd=3), ivalid=1 at edge 0:
  - cycle 1: Aselect=32'h2, Bselect=32'h4, S=010, Cin=0.
  - cycle 1+DLAT: Dselect=32'h8.
  - Other cycles: Dselect=0.
- SUB r5=r1-r2 then independent XOR r6=r3^r4 back-to-back -> no stall; S=011/Cin=1 then S=000/Cin=0 on consecutive cycles; Dselect 32'h20 then 32'h40.
- ADD r3 followed immediately by OR r4=r3|r1 -> stall=1 for exactly 2 cycles (DLAT=2) with bubbles issued; the OR issues when r3's Dselect has just retired.
- ADD with rd=0, then a reader of r0 -> Dselect stays 0 and there is no stall. Illegal op 111111 -> bubble outputs and Dselect=0 two cycles later.
- Reset asserted while stall=1 -> stall drops immediately and pipeline stages clear. The held instruction is discarded: after deassertion, Dselect stays 0 until a fresh instruction issues.

Source files
------------

// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the instruction-decode stage:
//   - opcode and ALU function encodings
//   - instruction field bit positions
//   - the select value driven while a bubble is issued
//   - the legal range of the destination-pipeline depth
//   - decode_op(): maps an opcode to its ALU control, or flags it as illegal
// ----------------------------------------------------------------------------
package decode_pkg;

    localparam int DLAT_MIN = 1;
    localparam int DLAT_MAX = 4;

    // Instruction field positions: op | rs (A) | rt (B) | rd (D) | unused
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    // A bubble reads R0 on both operands.
    localparam logic [31:0] SEL_NONE = 32'h0000_0001;

    typedef enum logic [5:0] {
        OP_XOR = 6'b000000,
        OP_AND = 6'b000001,
        OP_SUB = 6'b000010,
        OP_ADD = 6'b000011,
        OP_OR  = 6'b000100,
        OP_NOR = 6'b000101
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_XOR = 3'b000,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_OR  = 3'b100,
        ALU_NOR = 3'b101,
        ALU_AND = 3'b110
    } alu_fn_e;

    typedef struct packed {
        logic    legal;
        alu_fn_e fn;
        logic    cin;
    } alu_ctrl_t;

    function automatic alu_ctrl_t decode_op(input logic [5:0] op);
        alu_ctrl_t c;
        c.legal = 1'b1;
        c.fn    = ALU_XOR;
        c.cin   = 1'b0;
        case (op)
            OP_XOR:  c.fn = ALU_XOR;
            OP_AND:  c.fn = ALU_AND;
            OP_SUB:  begin c.fn = ALU_SUB; c.cin = 1'b1; end
            OP_ADD:  c.fn = ALU_ADD;
            OP_OR:   c.fn = ALU_OR;
            OP_NOR:  c.fn = ALU_NOR;
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_onehot5to32.sv
// ----------------------------------------------------------------------------
// onehot5to32
// Combinational 5-bit index to 32-bit one-hot decoder.
//   idx_i    [4:0]  register index
//   onehot_o [31:0] bit idx_i set, all others clear
// ----------------------------------------------------------------------------
module onehot5to32 (
    input  logic [4:0]  idx_i,
    output logic [31:0] onehot_o
);

    assign onehot_o = 32'h0000_0001 << idx_i;

endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Instruction-decode stage feeding a register file and a pipelined ALU.
// Latches the instruction word, issues one-hot operand selects and the ALU
// function, and delays the one-hot write select by DLAT cycles so it lines
// up with the ALU result. Read-after-write hazards against destinations still
// in the delay pipeline stall fetch and issue bubbles.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ibus     in   [31:0] instruction word from fetch
//   ivalid   in   ibus is valid this cycle
//   stall    out  fetch must hold ibus/ivalid (combinational)
//   Aselect  out  [31:0] one-hot operand A select
//   Bselect  out  [31:0] one-hot operand B select
//   Dselect  out  [31:0] one-hot write select, zero = no write
//   S        out  [2:0] ALU function
//   Cin      out  ALU carry-in
// ----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int DLAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ibus,
    input  logic        ivalid,
    output logic        stall,
    output logic [31:0] Aselect,
    output logic [31:0] Bselect,
    output logic [31:0] Dselect,
    output logic [2:0]  S,
    output logic        Cin
);

    // Out-of-range depths are clamped to the nearest legal value.
    localparam int NSTG = (DLAT < DLAT_MIN) ? DLAT_MIN :
                          (DLAT > DLAT_MAX) ? DLAT_MAX : DLAT;

    logic [31:0] ir_q, ir_d;
    logic        irv_q, irv_d;
    logic [31:0] dst_q [NSTG];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_oh, rt_oh, rd_oh;
    logic [31:0] in_flight;
    logic [31:0] dst_push;
    logic        rs_hit, rt_hit, issue;
    alu_ctrl_t   ctrl;

    assign op   = ir_q[OP_MSB:OP_LSB];
    assign rs   = ir_q[RS_MSB:RS_LSB];
    assign rt   = ir_q[RT_MSB:RT_LSB];
    assign rd   = ir_q[RD_MSB:RD_LSB];
    assign ctrl = decode_op(op);

    // The low instruction bits carry no meaning for this datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[RD_LSB-1:0];

    onehot5to32 u_rs_dec (.idx_i(rs), .onehot_o(rs_oh));
    onehot5to32 u_rt_dec (.idx_i(rt), .onehot_o(rt_oh));
    onehot5to32 u_rd_dec (.idx_i(rd), .onehot_o(rd_oh));

    // Every stage, including the one driving Dselect, is still in flight:
    // the register file only commits it at the end of this cycle.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        in_flight = '0;
        for (int i = 0; i < NSTG; i++) begin
            in_flight = in_flight | dst_q[i];
        end
    end

    assign rs_hit = (rs != 5'd0) && (|(rs_oh & in_flight));
    assign rt_hit = (rt != 5'd0) && (|(rt_oh & in_flight));
    assign stall  = irv_q && ctrl.legal && (rs_hit || rt_hit);
    assign issue  = irv_q && ctrl.legal && !stall;

    always_comb begin
        Aselect  = SEL_NONE;
        Bselect  = SEL_NONE;
        S        = ALU_XOR;
        Cin      = 1'b0;
        dst_push = '0;
        if (issue) begin
            Aselect = rs_oh;
            Bselect = rt_oh;
            S       = ctrl.fn;
            Cin     = ctrl.cin;
            // R0 is hardwired: a write to it is dropped here.
            if (rd != 5'd0) begin
                dst_push = rd_oh;
            end
        end
    end

    // A stalled instruction stays in IR; fetch holds its side meanwhile.
    assign ir_d  = stall ? ir_q  : ibus;
    assign irv_d = stall ? irv_q : ivalid;

    assign Dselect = dst_q[NSTG-1];

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values and the shift pipeline moves one stage per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q  <= '0;
            irv_q <= 1'b0;
            // NOTE: the destination array is reset explicitly because in-flight
            // writes must be discarded; a stale entry would corrupt a register.
            for (int i = 0; i < NSTG; i++) begin
                dst_q[i] <= '0;
            end
        end else begin
            ir_q     <= ir_d;
            irv_q    <= irv_d;
            dst_q[0] <= dst_push;
            for (int i = 1; i < NSTG; i++) begin
                dst_q[i] <= dst_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
// Directed self-checking bench for decode_stage with DLAT=2. Each task drives
// a short instruction sequence; at every falling edge it compares all outputs
// against a hand-computed vector, then drives the input for the next edge.
// ----------------------------------------------------------------------------
module tb_decode_stage;

    typedef struct packed {
        logic        stall;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [2:0]  s;
        logic        cin;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ibus;
    logic        ivalid;
    logic        stall;
    logic [31:0] Aselect, Bselect, Dselect;
    logic [2:0]  S;
    logic        Cin;

    int errors = 0;
    int checks = 0;

    decode_stage #(.DLAT(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ibus    (ibus),
        .ivalid  (ivalid),
        .stall   (stall),
        .Aselect (Aselect),
        .Bselect (Bselect),
        .Dselect (Dselect),
        .S       (S),
        .Cin     (Cin)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [5:0] op, input int rs, input int rt, input int rd);
        logic [4:0] a, b, d;
        a = rs[4:0];
        b = rt[4:0];
        d = rd[4:0];
        return {op, a, b, d, 11'h0};
    endfunction

    function automatic out_t iss(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] s, input logic cin, input logic [31:0] d);
        out_t o;
        o.stall = 1'b0; o.a = a; o.b = b; o.d = d; o.s = s; o.cin = cin;
        return o;
    endfunction

    function automatic out_t bub(input logic st, input logic [31:0] d);
        out_t o;
        o.stall = st; o.a = 32'h1; o.b = 32'h1; o.d = d; o.s = 3'b000; o.cin = 1'b0;
        return o;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.stall = stall; o.a = Aselect; o.b = Bselect; o.d = Dselect; o.s = S; o.cin = Cin;
        return o;
    endfunction

    localparam logic [5:0] XOR_OP = 6'b000000;
    localparam logic [5:0] SUB_OP = 6'b000010;
    localparam logic [5:0] ADD_OP = 6'b000011;
    localparam logic [5:0] OR_OP  = 6'b000100;
    localparam logic [5:0] BAD_OP = 6'b111111;

    task automatic test_reset();
        out_t got, exp;
        rst_n = 1'b1; ibus = '0; ivalid = 1'b0;
        #3 rst_n = 1'b0;
        #1 got = observe();
        exp = bub(1'b0, 32'h0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_initial: got %h want %h", got, exp);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        logic [31:0] vi [5];
        logic        vv [5];
        out_t        ve [5];
        out_t        got;
        vi = '{ins(ADD_OP, 1, 2, 3), 32'h0, 32'h0, 32'h0, 32'h0};
        vv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ve = '{bub(1'b0, 32'h0), iss(32'h2, 32'h4, 3'b010, 1'b0, 32'h0),
               bub(1'b0, 32'h0), bub(1'b0, 32'h8), bub(1'b0, 32'h0)};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL single_add[%0d]: got %h want %h", i, got, ve[i]);
            end
            ibus = vi[i]; ivalid = vv[i];
        end
    endtask

    task automatic test_independent();
        logic [31:0] vi [6];
        logic        vv [6];
        out_t        ve [6];
        out_t        got;
        vi = '{ins(SUB_OP, 1, 2, 5), ins(XOR_OP, 3, 4, 6), 32'h0, 32'h0, 32'h0, 32'h0};
        vv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ve = '{bub(1'b0, 32'h0),
               iss(32'h2, 32'h4,  3'b011, 1'b1, 32'h0),
               iss(32'h8, 32'h10, 3'b000, 1'b0, 32'h0),
               bub(1'b0, 32'h20), bub(1'b0, 32'h40), bub(1'b0, 32'h0)};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL independent[%0d]: got %h want %h", i, got, ve[i]);
            end
            ibus = vi[i]; ivalid = vv[i];
        end
    endtask

    // OR r4 = r3 | r1 right behind ADD r3: stalls DLAT=2 cycles, fetch holds.
    task automatic test_back_to_back();
        logic [31:0] vi [8];
        logic        vv [8];
        out_t        ve [8];
        out_t        got;
        vi = '{ins(ADD_OP, 1, 2, 3), ins(OR_OP, 3, 1, 4), ins(OR_OP, 3, 1, 4),
               ins(OR_OP, 3, 1, 4), 32'h0, 32'h0, 32'h0, 32'h0};
        vv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ve = '{bub(1'b0, 32'h0),
               iss(32'h2, 32'h4, 3'b010, 1'b0, 32'h0),
               bub(1'b1, 32'h0), bub(1'b1, 32'h8),
               iss(32'h8, 32'h2, 3'b100, 1'b0, 32'h0),
               bub(1'b0, 32'h0), bub(1'b0, 32'h10), bub(1'b0, 32'h0)};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, got, ve[i]);
            end
            ibus = vi[i]; ivalid = vv[i];
        end
    endtask

    // ADD r0, then OR r5 = r0 | r1 (no stall), then an illegal op reading r5.
    task automatic test_r0_and_illegal();
        logic [31:0] vi [7];
        logic        vv [7];
        out_t        ve [7];
        out_t        got;
        vi = '{ins(ADD_OP, 1, 2, 0), ins(OR_OP, 0, 1, 5), ins(BAD_OP, 5, 5, 7),
               32'h0, 32'h0, 32'h0, 32'h0};
        vv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ve = '{bub(1'b0, 32'h0),
               iss(32'h2, 32'h4, 3'b010, 1'b0, 32'h0),
               iss(32'h1, 32'h2, 3'b100, 1'b0, 32'h0),
               bub(1'b0, 32'h0), bub(1'b0, 32'h20), bub(1'b0, 32'h0), bub(1'b0, 32'h0)};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL r0_illegal[%0d]: got %h want %h", i, got, ve[i]);
            end
            ibus = vi[i]; ivalid = vv[i];
        end
    endtask

    // ADD r3 in flight (stage 1) when reset hits: its write must never appear.
    task automatic test_reset_mid();
        out_t got, exp;
        @(negedge clk);
        ibus = ins(ADD_OP, 1, 2, 3); ivalid = 1'b1;
        @(negedge clk);
        got = observe();
        exp = iss(32'h2, 32'h4, 3'b010, 1'b0, 32'h0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_issue: got %h want %h", got, exp);
        end
        ibus = '0; ivalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = observe();
            exp = bub(1'b0, 32'h0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    // Reset while stalled with r3 driving Dselect; then a fresh ADD recovers.
    task automatic test_reset_stall();
        logic [31:0] vi [4];
        logic        vv [4];
        out_t        ve [4];
        out_t        got, exp;
        vi = '{ins(ADD_OP, 1, 2, 3), ins(OR_OP, 3, 1, 4), ins(OR_OP, 3, 1, 4), ins(OR_OP, 3, 1, 4)};
        vv = '{1'b1, 1'b1, 1'b1, 1'b1};
        ve = '{bub(1'b0, 32'h0), iss(32'h2, 32'h4, 3'b010, 1'b0, 32'h0),
               bub(1'b1, 32'h0), bub(1'b1, 32'h8)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL reset_stall_pre[%0d]: got %h want %h", i, got, ve[i]);
            end
            ibus = vi[i]; ivalid = vv[i];
        end
        rst_n = 1'b0;
        #1 got = observe();
        exp = bub(1'b0, 32'h0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_stall_async: got %h want %h", got, exp);
        end
        @(negedge clk);
        ibus = '0; ivalid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_stall_after[%0d]: got %h want %h", i, got, exp);
            end
        end
        vi = '{ins(ADD_OP, 1, 2, 3), 32'h0, 32'h0, 32'h0};
        vv = '{1'b1, 1'b0, 1'b0, 1'b0};
        ve = '{iss(32'h2, 32'h4, 3'b010, 1'b0, 32'h0), bub(1'b0, 32'h0),
               bub(1'b0, 32'h8), bub(1'b0, 32'h0)};
        ibus = vi[0]; ivalid = vv[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL reset_stall_recover[%0d]: got %h want %h", i, got, ve[i]);
            end
            if (i < 3) begin
                ibus = vi[i+1]; ivalid = vv[i+1];
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_independent();
        test_back_to_back();
        test_r0_and_illegal();
        test_reset_mid();
        test_reset_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete within 50000 time units");
        $fatal(1, "timeout");
    end

endmodule
